// File: rtl/multi_cycle_control.sv
// ----------------------------------------------------------------------------
// multi_cycle_control
//
// Moore control FSM for a multi-cycle MIPS-style datapath. One instruction is
// walked through FETCH -> DECODE -> (execute / memory / write-back) states.
// The control word is registered: it is computed from the next state when the
// state register updates, so it always equals the decode of the current state.
// The following outputs also depend on inputs in the current cycle:
//   - IRWrite and PCWrite in FETCH follow MemReady, so the instruction and
//     PC+4 are captured in the cycle the fetch completes.
//   - IllegalOp is raised in DECODE for an unsupported Opcode.
//   - Every output, State included, is forced to 0 while Reset is high.
//
// Parameters
//   STATE_W      width of the State debug output
// Ports
//   CLK          clock, rising edge active
//   Reset        synchronous active-high reset
//   Opcode[5:0]  instruction bits [31:26]
//   Func[5:0]    instruction bits [5:0]
//   MemReady     memory access completes this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
//   RegDst, RegWrite, SignExtend, ALUSrcA      datapath controls
//   ALUSrcB[1:0]   00 B, 01 const 4, 10 ext imm, 11 ext imm << 2
//   PCSource[1:0]  00 ALU result, 01 ALUOut, 10 jump target
//   ALUOp[3:0]     ALU operation code (1111 = decode from Func)
//   IllegalOp      one-cycle pulse for an unsupported opcode
//   State          current state encoding (debug)
// ----------------------------------------------------------------------------
module multi_cycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Func,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               SignExtend,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [3:0]         ALUOp,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_ITEXE  = 4'd8,
        S_ITWB   = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       sign_ext;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ADDU = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_LUI  = 4'b1110;
    localparam logic [3:0] ALU_FUNC = 4'b1111;

    // All I-type ALU opcodes share the 001xxx prefix.
    function automatic logic is_itype(input logic [5:0] op);
        return op[5:3] == 3'b001;
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || is_itype(op);
    endfunction

    function automatic logic [3:0] itype_alu_op(input logic [5:0] op);
        logic [3:0] r;
        case (op)
            OP_ADDI:  r = ALU_ADD;
            OP_ADDIU: r = ALU_ADDU;
            OP_ANDI:  r = ALU_AND;
            OP_ORI:   r = ALU_OR;
            OP_XORI:  r = ALU_XOR;
            OP_SLTI:  r = ALU_SLT;
            OP_SLTIU: r = ALU_SLTU;
            default:  r = ALU_LUI;
        endcase
        return r;
    endfunction

    // Control word for a state; op only matters for ITEXE.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                // Branch target PC+4 + (imm << 2) is precomputed here.
                c.alu_src_b = 2'b11;
                c.sign_ext  = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.sign_ext  = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_RTEXE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNC;
            end
            S_RTWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_ITEXE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = itype_alu_op(op);
                c.sign_ext  = (op == OP_ADDI) || (op == OP_SLTI) ||
                              (op == OP_SLTIU);
            end
            S_ITWB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    // Func does not change the control word: shift and non-shift R-types all
    // assert ALUSrcA in RTEXE, and the ALU picks shamt from the function
    // field itself.
    logic unused_func;
    assign unused_func = ^Func;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (Opcode == OP_RTYPE)                        state_d = S_RTEXE;
                else if ((Opcode == OP_LW) || (Opcode == OP_SW)) state_d = S_MEMADR;
                else if (Opcode == OP_BEQ)                     state_d = S_BRANCH;
                else if (Opcode == OP_J)                       state_d = S_JUMP;
                else if (is_itype(Opcode))                     state_d = S_ITEXE;
                else                                           state_d = S_FETCH;
            end
            S_MEMADR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
            S_RTEXE:  state_d = S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_ITEXE:  state_d = S_ITWB;
            S_ITWB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
        // Opcode is still held in the instruction register when entering
        // ITEXE, so its ALU operation can be registered on that edge.
        ctrl_d = ctrl_for(state_d, Opcode);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_for(S_FETCH, 6'd0);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    logic run;
    logic in_fetch;
    assign run      = ~Reset;
    assign in_fetch = (state_q == S_FETCH);

    assign PCWrite     = run & (ctrl_q.pc_write | (in_fetch & MemReady));
    assign IRWrite     = run & in_fetch & MemReady;
    assign MemRead     = run & ctrl_q.mem_read;
    assign PCWriteCond = run & ctrl_q.pc_write_cond;
    assign IorD        = run & ctrl_q.iord;
    assign MemWrite    = run & ctrl_q.mem_write;
    assign MemToReg    = run & ctrl_q.mem_to_reg;
    assign RegDst      = run & ctrl_q.reg_dst;
    assign RegWrite    = run & ctrl_q.reg_write;
    assign SignExtend  = run & ctrl_q.sign_ext;
    assign ALUSrcA     = run & ctrl_q.alu_src_a;
    assign ALUSrcB     = run ? ctrl_q.alu_src_b : 2'b00;
    assign PCSource    = run ? ctrl_q.pc_source : 2'b00;
    assign ALUOp       = run ? ctrl_q.alu_op : 4'b0000;
    assign IllegalOp   = run & (state_q == S_DECODE) & ~is_legal(Opcode);
    assign State       = run ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_multi_cycle_control.sv
// ----------------------------------------------------------------------------
// tb_multi_cycle_control
//
// Drives whole instructions (with chosen memory stall counts) into the control
// FSM and compares every cycle's State and control outputs against a model
// that builds the expected state trace from the per-instruction flow and
// latency rules, and looks up each state's control values from a table.
// ----------------------------------------------------------------------------
module tb_multi_cycle_control;

    localparam int STATE_W = 4;

    logic               CLK;
    logic               Reset;
    logic [5:0]         Opcode;
    logic [5:0]         Func;
    logic               MemReady;
    logic               PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic               MemToReg, RegDst, RegWrite, SignExtend, ALUSrcA;
    logic [1:0]         ALUSrcB, PCSource;
    logic [3:0]         ALUOp;
    logic               IllegalOp;
    logic [STATE_W-1:0] State;

    int tests = 0;
    int fails = 0;

    multi_cycle_control #(.STATE_W(STATE_W)) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Func(Func),
        .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .SignExtend(SignExtend), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
        .IllegalOp(IllegalOp), .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Opcodes the block supports, and the named ones the tests use.
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010;
    localparam logic [5:0] ANDI = 6'b001100, SLTI = 6'b001010;
    logic [5:0] legal_ops [13] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                   6'b000010, 6'b001000, 6'b001001, 6'b001100,
                                   6'b001101, 6'b001110, 6'b001010, 6'b001011,
                                   6'b001111};

    function automatic bit op_legal(input logic [5:0] op);
        foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Packed view of the outputs, same order as the expected vector.
    function automatic logic [19:0] dut_ctrl();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemToReg, RegDst, RegWrite, SignExtend, ALUSrcA, ALUSrcB,
                PCSource, ALUOp, IllegalOp};
    endfunction

    // Required output values in a given state.
    function automatic logic [19:0] spec_ctrl(input int st, input logic [5:0] op,
                                              input bit mr);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mw = 0, irw = 0;
        logic m2r = 0, rdst = 0, rw = 0, sx = 0, sa = 0, ill = 0;
        logic [1:0] sb = 0, ps = 0;
        logic [3:0] aop = 0;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; aop = 4'b0010; irw = mr; pcw = mr; end
            1:  begin sb = 2'b11; sx = 1; aop = 4'b0010; ill = !op_legal(op); end
            2:  begin sa = 1; sb = 2'b10; sx = 1; aop = 4'b0010; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin sa = 1; aop = 4'b1111; end
            7:  begin rw = 1; rdst = 1; end
            8: begin
                sa = 1; sb = 2'b10;
                case (op)
                    6'b001000: begin aop = 4'b0010; sx = 1; end  // ADDI
                    6'b001001: aop = 4'b1000;                    // ADDIU
                    6'b001100: aop = 4'b0000;                    // ANDI
                    6'b001101: aop = 4'b0001;                    // ORI
                    6'b001110: aop = 4'b1010;                    // XORI
                    6'b001010: begin aop = 4'b0111; sx = 1; end  // SLTI
                    6'b001011: begin aop = 4'b1011; sx = 1; end  // SLTIU
                    default:   aop = 4'b1110;                    // LUI
                endcase
            end
            9:  rw = 1;
            10: begin sa = 1; aop = 4'b0110; pcwc = 1; ps = 2'b01; end
            11: begin pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mw, irw, m2r, rdst, rw, sx, sa, sb, ps,
                aop, ill};
    endfunction

    // Runs one instruction: sf fetch stalls, sm memory stalls. Stops after
    // stop_after cycles when stop_after >= 0.
    task automatic run_instr(input string name, input logic [5:0] op,
                             input logic [5:0] fn, input int sf, input int sm,
                             input int stop_after);
        int st[$];
        bit mr[$];
        int n;
        for (int i = 0; i < sf; i++) begin st.push_back(0); mr.push_back(0); end
        st.push_back(0); mr.push_back(1);
        st.push_back(1); mr.push_back(1'($urandom));
        if (op == LW) begin
            st.push_back(2); mr.push_back(1'($urandom));
            for (int i = 0; i < sm; i++) begin st.push_back(3); mr.push_back(0); end
            st.push_back(3); mr.push_back(1);
            st.push_back(4); mr.push_back(1'($urandom));
        end else if (op == SW) begin
            st.push_back(2); mr.push_back(1'($urandom));
            for (int i = 0; i < sm; i++) begin st.push_back(5); mr.push_back(0); end
            st.push_back(5); mr.push_back(1);
        end else if (op == RT) begin
            st.push_back(6); st.push_back(7);
            mr.push_back(1'($urandom)); mr.push_back(1'($urandom));
        end else if (op[5:3] == 3'b001) begin
            st.push_back(8); st.push_back(9);
            mr.push_back(1'($urandom)); mr.push_back(1'($urandom));
        end else if (op == BEQ) begin
            st.push_back(10); mr.push_back(1'($urandom));
        end else if (op == JMP) begin
            st.push_back(11); mr.push_back(1'($urandom));
        end
        n = (stop_after >= 0 && stop_after < st.size()) ? stop_after : st.size();
        for (int i = 0; i < n; i++) begin
            bit sampled;
            logic [19:0] exp_c, got_c;
            @(negedge CLK);
            sampled  = (st[i] == 1) || (st[i] == 2) || (st[i] == 6) || (st[i] == 8);
            Opcode   = sampled ? op : 6'($urandom);
            Func     = sampled ? fn : 6'($urandom);
            MemReady = mr[i];
            #1;
            tests++;
            if (State !== STATE_W'(st[i])) begin
                fails++;
                $display("FAIL %s state cyc%0d: got %0d want %0d", name, i, State, st[i]);
            end
            exp_c = spec_ctrl(st[i], op, mr[i]);
            got_c = dut_ctrl();
            tests++;
            if (got_c !== exp_c) begin
                fails++;
                $display("FAIL %s ctrl cyc%0d st%0d: got %b want %b", name, i,
                         st[i], got_c, exp_c);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; MemReady = 1'b1; Opcode = 6'($urandom); Func = 6'($urandom);
        repeat (3) @(posedge CLK);
        @(negedge CLK); #1;
        tests++;
        if (State !== '0 || dut_ctrl() !== 20'd0) begin
            fails++;
            $display("FAIL reset_hold: state %0d ctrl %b want 0 / 0", State, dut_ctrl());
        end
        @(negedge CLK);
        Reset = 1'b0; MemReady = 1'b0;
        #1;
        tests++;
        if (State !== '0 || dut_ctrl() !== spec_ctrl(0, 6'd0, 1'b0)) begin
            fails++;
            $display("FAIL reset_release: state %0d ctrl %b want 0 / %b", State,
                     dut_ctrl(), spec_ctrl(0, 6'd0, 1'b0));
        end
    endtask

    task automatic test_lw();
        run_instr("lw", LW, 6'($urandom), 0, 0, -1);
    endtask

    task automatic test_sw_stall();
        run_instr("sw_stall", SW, 6'($urandom), 0, 3, -1);
        run_instr("after_sw", BEQ, 6'($urandom), 0, 0, -1);
    endtask

    task automatic test_rtype_shift();
        run_instr("rtype_srl", RT, 6'b000010, 0, 0, -1);
    endtask

    task automatic test_itype();
        run_instr("andi", ANDI, 6'($urandom), 1, 0, -1);
        run_instr("slti", SLTI, 6'($urandom), 0, 0, -1);
        run_instr("jump", JMP, 6'($urandom), 2, 0, -1);
    endtask

    task automatic test_illegal();
        run_instr("illegal", 6'b111111, 6'($urandom), 0, 0, -1);
        run_instr("after_illegal", RT, 6'b100000, 0, 0, -1);
    endtask

    task automatic test_reset_in_wait();
        // FETCH, DECODE, MEMADR, then one MEMRD cycle with MemReady low.
        run_instr("lw_wait", LW, 6'($urandom), 0, 5, 4);
        @(negedge CLK);
        Reset = 1'b1; MemReady = 1'b0;
        #1;
        tests++;
        if (State !== '0 || dut_ctrl() !== 20'd0) begin
            fails++;
            $display("FAIL wait_reset_hold: state %0d ctrl %b want 0 / 0", State, dut_ctrl());
        end
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        tests++;
        if (State !== '0 || dut_ctrl() !== spec_ctrl(0, 6'd0, 1'b0)) begin
            fails++;
            $display("FAIL wait_reset_next: state %0d ctrl %b want 0 / %b", State,
                     dut_ctrl(), spec_ctrl(0, 6'd0, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 60; k++) begin
            logic [5:0] op;
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom_range(0, 12)];
            run_instr("random", op, 6'($urandom), $urandom_range(0, 2),
                      $urandom_range(0, 3), -1);
        end
    endtask

    initial begin
        Reset = 1'b1; Opcode = '0; Func = '0; MemReady = 1'b0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_rtype_shift();
        test_itype();
        test_illegal();
        test_reset_in_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
